// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port Memory between instruction fetch and load/store.
// Optional MEM_ARB_ADDR_CHECK_EN rejects latched addresses outside the low 4 KiB window.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int STROBE_CYCLES = 1,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);
    localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t            state, state_nxt;
    logic              sel_dm, sel_dm_nxt;
    logic              lat_we, lat_we_nxt;
    logic [CW-1:0]     strobe_cnt, strobe_cnt_nxt;
    logic [SW-1:0]     starve_cnt, starve_cnt_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_din_nxt, if_rdata_nxt, dm_rdata_nxt;
    logic              mem_ren_nxt, mem_wen_nxt, if_ack_nxt, dm_ack_nxt, err_nxt, busy_nxt;
    logic              elig_if, elig_dm, pick_if, pick_dm, addr_bad;

`ifdef MEM_ARB_ADDR_CHECK_EN
    assign addr_bad = (mem_addr >> 12) != '0;
`else
    assign addr_bad = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel_dm     <= 1'b0;
            lat_we     <= 1'b0;
            strobe_cnt <= '0;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel_dm     <= sel_dm_nxt;
            lat_we     <= lat_we_nxt;
            strobe_cnt <= strobe_cnt_nxt;
            starve_cnt <= starve_cnt_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_din    <= mem_din_nxt;
            mem_ren    <= mem_ren_nxt;
            mem_wen    <= mem_wen_nxt;
            if_ack     <= if_ack_nxt;
            dm_ack     <= dm_ack_nxt;
            if_rdata   <= if_rdata_nxt;
            dm_rdata   <= dm_rdata_nxt;
            err        <= err_nxt;
            busy       <= busy_nxt;
        end
    end

    // In HOLD only the port that was not just served may be granted.
    always_comb begin
        elig_if = 1'b0;
        elig_dm = 1'b0;
        if (state == IDLE) begin
            elig_if = if_req;
            elig_dm = dm_req;
        end else if (state == HOLD) begin
            elig_if = if_req && sel_dm;
            elig_dm = dm_req && !sel_dm;
        end
        pick_dm = elig_dm && (!elig_if || starve_cnt != STARVE_MAX);
        pick_if = elig_if && !pick_dm;
    end

    always_comb begin
        state_nxt      = state;
        sel_dm_nxt     = sel_dm;
        lat_we_nxt     = lat_we;
        strobe_cnt_nxt = strobe_cnt;
        starve_cnt_nxt = starve_cnt;
        mem_addr_nxt   = mem_addr;
        mem_din_nxt    = mem_din;
        mem_ren_nxt    = 1'b0;
        mem_wen_nxt    = 1'b0;
        if_ack_nxt     = 1'b0;
        dm_ack_nxt     = 1'b0;
        if_rdata_nxt   = if_rdata;
        dm_rdata_nxt   = dm_rdata;
        err_nxt        = 1'b0;

        case (state)
            IDLE: ;
            SETUP: begin
                if (addr_bad) begin
                    state_nxt = HOLD;
                    err_nxt   = 1'b1;
                    if (sel_dm) begin
                        dm_ack_nxt   = 1'b1;
                        dm_rdata_nxt = '0;
                    end else begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = '0;
                    end
                end else begin
                    state_nxt      = STROBE;
                    strobe_cnt_nxt = '0;
                    mem_ren_nxt    = !lat_we;
                    mem_wen_nxt    = lat_we;
                end
            end
            STROBE: begin
                if (strobe_cnt == STROBE_LAST) begin
                    state_nxt = HOLD;
                    if (sel_dm) begin
                        dm_ack_nxt   = 1'b1;
                        dm_rdata_nxt = mem_dout;
                    end else begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = mem_dout;
                    end
                end else begin
                    strobe_cnt_nxt = strobe_cnt + 1'b1;
                    mem_ren_nxt    = !lat_we;
                    mem_wen_nxt    = lat_we;
                end
            end
            HOLD: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // A grant latches the payload; later changes on the request inputs are ignored.
        if (pick_dm || pick_if) begin
            state_nxt  = SETUP;
            sel_dm_nxt = pick_dm;
            if (pick_dm) begin
                mem_addr_nxt = dm_addr;
                mem_din_nxt  = dm_wdata;
                lat_we_nxt   = dm_we;
                if (if_req && starve_cnt != STARVE_MAX)
                    starve_cnt_nxt = starve_cnt + 1'b1;
            end else begin
                mem_addr_nxt   = if_addr;
                lat_we_nxt     = 1'b0;
                starve_cnt_nxt = '0;
            end
        end

        busy_nxt = (state_nxt != IDLE);
    end
endmodule
